mem_responder: RTL and testbench

Data/instruction memory responder on the memory side of the CPU's mem_en/mem_wr/mem_size interface. It accepts one load or store request at a time and executes it against a word-wide synchronous RAM that has no byte enables, using read-modify-write for sub-word stores. Load data is returned sign- or zero-extended according to funct3. Its only consumer is the multi-cycle control unit, which holds a request until the responder signals ready.

---
 rtl/mem_responder_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for mem_responder: funct3 size codes, FSM states and RAM timing.
package mem_responder_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Cycles from ram_re to valid ram_rdata; the WAIT state is sized for exactly this.
  localparam int unsigned RAM_RD_LAT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StWait,
    StWrA,
    StWrB,
    StDone
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // 011/11x are undefined; unsigned sizes only exist for loads.
  function automatic logic size_illegal(input logic [2:0] size, input logic wr);
    return (size == 3'b011) || (size[2] && size[1]) || (size[2] && wr);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store merge into a word pair and load extract/extend.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] word_a,
  input  logic [31:0] word_b,
  output logic [31:0] wr_word_a,
  output logic [31:0] wr_word_b,
  output logic [31:0] load_data
);

  logic [7:0]  size_mask;
  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] old_pair;
  logic [63:0] shifted;
  logic [63:0] new_pair;
  logic [31:0] load_word;

  always_comb begin
    old_pair = {word_b, word_a};
    case (size[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      default: size_mask = 8'h0F;
    endcase
    byte_mask = size_mask << offset;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    shifted   = {32'b0, wdata} << {offset, 3'b000};
    new_pair  = (old_pair & ~bit_mask) | (shifted & bit_mask);
    wr_word_a = new_pair[31:0];
    wr_word_b = new_pair[63:32];

    load_word = old_pair[{offset, 3'b000} +: 32];
    case (size)
      SZ_B:    load_data = {{24{load_word[7]}}, load_word[7:0]};
      SZ_H:    load_data = {{16{load_word[15]}}, load_word[15:0]};
      SZ_BU:   load_data = {24'b0, load_word[7:0]};
      SZ_HU:   load_data = {16'b0, load_word[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Load/store responder over a byte-enable-less word RAM using read-modify-write.
// Define MEM_RESPONDER_MISALIGNED_EN to split word-crossing accesses; otherwise they fault.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [2:0]        mem_size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              fault,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] word_q;
  logic [1:0]        off_q;
  logic [2:0]        size_q;
  logic              wr_q;
  logic              span_q;
  logic              fault_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_a_q;
  logic [31:0]       word_b_q;
  logic [31:0]       rdata_q;

  logic [1:0]  acc_off;
  logic [2:0]  acc_bytes;
  logic        acc_span;
  logic        acc_fault;
  logic        acc_sw;
  logic        accept;
  logic [31:0] in_a, in_b;
  logic [31:0] wr_word_a, wr_word_b, load_data;

  // Upper address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  always_comb begin
    acc_off   = addr[1:0];
    acc_bytes = size_bytes(mem_size);
`ifdef MEM_RESPONDER_MISALIGNED_EN
    acc_span  = ({1'b0, acc_off} + acc_bytes) > 3'd4;
    acc_fault = size_illegal(mem_size, mem_wr);
`else
    acc_span  = 1'b0;
    acc_fault = size_illegal(mem_size, mem_wr) ||
                (acc_bytes[1] && acc_off[0]) || (acc_bytes[2] && (acc_off != 2'd0));
`endif
    acc_sw    = mem_wr && (mem_size == SZ_W) && (acc_off == 2'd0);
    accept    = (state_q == StIdle) && mem_en;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mem_en) begin
          if (acc_fault)   state_d = StDone;
          else if (acc_sw) state_d = StWrA;
          else             state_d = StRdA;
        end
      end
      StRdA:  state_d = span_q ? StRdB : StWait;
`ifdef MEM_RESPONDER_MISALIGNED_EN
      StRdB:  state_d = StWait;
      StWrB:  state_d = StDone;
`endif
      StWait: state_d = wr_q ? StWrA : StDone;
      StWrA:  state_d = span_q ? StWrB : StDone;
      StDone: if (!mem_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      span_q   <= 1'b0;
      fault_q  <= 1'b0;
      wdata_q  <= '0;
      word_a_q <= '0;
      word_b_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        word_q  <= addr[ADDR_W+1:2];
        off_q   <= acc_off;
        size_q  <= mem_size;
        wr_q    <= mem_wr;
        span_q  <= acc_span;
        fault_q <= acc_fault;
        wdata_q <= wdata;
        rdata_q <= '0;
      end
      if (state_q == StRdB) word_a_q <= ram_rdata;
      if (state_q == StWait) begin
        if (span_q) word_b_q <= ram_rdata;
        else        word_a_q <= ram_rdata;
        if (!wr_q)  rdata_q  <= load_data;
      end
    end
  end

  // In WAIT the last word is still on ram_rdata, so the load path taps it directly.
  always_comb begin
    in_a = ((state_q == StWait) && !span_q) ? ram_rdata : word_a_q;
    in_b = ((state_q == StWait) && span_q)  ? ram_rdata : word_b_q;
  end

  mem_lane_align u_align (
    .offset    (off_q),
    .size      (size_q),
    .wdata     (wdata_q),
    .word_a    (in_a),
    .word_b    (in_b),
    .wr_word_a (wr_word_a),
    .wr_word_b (wr_word_b),
    .load_data (load_data)
  );

  always_comb begin
    ram_re    = (state_q == StRdA) || (state_q == StRdB);
    ram_we    = (state_q == StWrA) || (state_q == StWrB);
    ram_addr  = ((state_q == StRdB) || (state_q == StWrB)) ? word_q + ADDR_W'(1) : word_q;
    ram_wdata = (state_q == StWrB) ? wr_word_b : wr_word_a;
    ready     = (state_q == StDone);
    fault     = fault_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-array memory model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned NW = 1 << AW;
  localparam int unsigned NB = 4 * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en, mem_wr;
  logic [2:0]    mem_size;
  logic [31:0]   addr, wdata, rdata;
  logic          ready, fault;
  logic [AW-1:0] ram_addr;
  logic          ram_re, ram_we;
  logic [31:0]   ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int n_re = 0, n_we = 0, n_both = 0;
  logic [31:0] last_rdata;

  logic [31:0]   ram [NW];
  logic [7:0]    mdl [NB];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [31:0]   tb_data = '0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_size  (mem_size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .fault     (fault),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_re) n_re++;
    if (ram_we) n_we++;
    if (ram_re && ram_we) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int unsigned w, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = AW'(w); tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
    for (int i = 0; i < 4; i++) mdl[4*w + i] = d[8*i +: 8];
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] m;
    for (int w = 0; w < NW; w++) begin
      for (int i = 0; i < 4; i++) m[8*i +: 8] = mdl[4*w + i];
      check($sformatf("%s mem[%0d]", tag, w), ram[w], m);
    end
  endtask

  // Reference: byte-addressed memory, latency/access counts from access class.
  task automatic model(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic f, output logic [31:0] rd,
                       output int lat, output int nre, output int nwe);
    int unsigned n, off, base;
    logic span;
    logic [31:0] v;
    off  = a % 4;
    base = a % NB;
    n    = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    span = (off + n) > 4;
    f    = (sz == 3'd3) || (sz >= 3'd6) || (sz >= 3'd4 && wr);
`ifndef MEM_RESPONDER_MISALIGNED_EN
    if (off % n != 0) f = 1'b1;
`endif
    rd = '0; lat = 1; nre = 0; nwe = 0;
    if (f) return;
    if (wr) begin
      for (int unsigned i = 0; i < n; i++) mdl[(base + i) % NB] = wd[8*i +: 8];
      nwe = span ? 2 : 1;
      if (n == 4 && off == 0) lat = 2;
      else begin lat = span ? 6 : 4; nre = span ? 2 : 1; end
    end else begin
      v = '0;
      for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = mdl[(base + i) % NB];
      if (sz == SZ_B && v[7])  v[31:8]  = '1;
      if (sz == SZ_H && v[15]) v[31:16] = '1;
      rd = v; lat = span ? 4 : 3; nre = span ? 2 : 1;
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic ef;
    logic [31:0] er;
    int el, ere, ewe, re0, we0, lat;
    model(wr, sz, a, wd, ef, er, el, ere, ewe);
    @(negedge clk);
    mem_en = 1'b1; mem_wr = wr; mem_size = sz; addr = a; wdata = wd;
    re0 = n_re; we0 = n_we; lat = 0;
    do begin
      @(posedge clk); #1 lat++;
    end while (!ready && lat < 20);
    last_rdata = rdata;
    check({tag, " latency"}, lat, el);
    check({tag, " rdata"}, rdata, er);
    check({tag, " fault"}, fault, ef);
    check({tag, " ram_re count"}, n_re - re0, ere);
    check({tag, " ram_we count"}, n_we - we0, ewe);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 check({tag, " held ready"}, ready, 1'b1);
      check({tag, " held accesses"}, (n_re - re0) + (n_we - we0), ere + ewe);
    end
    @(negedge clk);
    mem_en = 1'b0; mem_wr = $urandom; mem_size = $urandom; addr = $urandom; wdata = $urandom;
    @(posedge clk);
    #1 check({tag, " ready low"}, ready, 1'b0);
  endtask

  initial begin
    logic [2:0] sz;
    int we0;
    rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_size = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", ready, 1'b0);
    check("reset fault", fault, 1'b0);
    check("reset rdata", rdata, 32'h0);
    check("reset strobes", {30'b0, ram_re, ram_we}, 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int w = 0; w < NW; w++) poke(w, $urandom);
    poke(0, 32'h11223344);
    poke(1, 32'h55667788);

    do_req("lb3", 1'b0, SZ_B, 32'd3, 32'h0, 0);
    check("lb3 value", last_rdata, 32'h00000011);
    do_req("lb4", 1'b0, SZ_B, 32'd4, 32'h0, 0);
    check("lb4 value", last_rdata, 32'hFFFFFF88);
    do_req("lbu4", 1'b0, SZ_BU, 32'd4, 32'h0, 0);
    check("lbu4 value", last_rdata, 32'h00000088);
    do_req("lw2", 1'b0, SZ_W, 32'd2, 32'h0, 0);
`ifdef MEM_RESPONDER_MISALIGNED_EN
    check("lw2 value", last_rdata, 32'h77881122);
`else
    check("lw2 value", last_rdata, 32'h0);
`endif
    do_req("sb1", 1'b1, SZ_B, 32'd1, 32'h000000AB, 0);
    check("sb1 word0", ram[0], 32'h1122AB44);
    do_req("sw4", 1'b1, SZ_W, 32'd4, 32'hDEADBEEF, 0);
    check("sw4 word1", ram[1], 32'hDEADBEEF);
    poke(0, 32'h11223344);
    poke(1, 32'h55667788);
    do_req("sh3", 1'b1, SZ_H, 32'd3, 32'h0000BEEF, 0);
    check_mem("sh3");
    poke(NW - 1, 32'h99AABBCC);
    do_req("sh wrap", 1'b1, SZ_H, 32'(4 * NW - 1), 32'h0000CAFE, 0);
    do_req("lh wrap", 1'b0, SZ_H, 32'(4 * NW - 1), 32'h0, 0);
    check_mem("wrap");

    // Async reset while an SB sits in WAIT: no write may follow.
    poke(0, 32'h11223344);
    @(negedge clk);
    mem_en = 1'b1; mem_wr = 1'b1; mem_size = SZ_B; addr = 32'd1; wdata = 32'h000000AB;
    we0 = n_we;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst strobes", {30'b0, ram_re, ram_we}, 32'h0);
    check("rst ready", ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) begin mem_en = 1'b0; rst = 1'b0; end
    repeat (2) @(posedge clk);
    #1 check("rst no write", n_we - we0, 0);
    check_mem("rst");
    do_req("lw0 after rst", 1'b0, SZ_W, 32'd0, 32'h0, 0);
    check("lw0 value", last_rdata, 32'h11223344);

    do_req("hold", 1'b0, SZ_B, 32'd5, 32'h0, 10);
    do_req("reassert", 1'b0, SZ_B, 32'd5, 32'h0, 0);
    do_req("size011", 1'b0, 3'b011, 32'd0, 32'h0, 0);
    do_req("lbu wr", 1'b1, SZ_BU, 32'd0, 32'h12345678, 0);
    check_mem("illegal");

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: sz = SZ_B;
        1: sz = SZ_H;
        2: sz = SZ_W;
        3: sz = SZ_BU;
        4: sz = SZ_HU;
        default: sz = 3'($urandom);
      endcase
      do_req($sformatf("rnd%0d", k), 1'($urandom), sz, $urandom, $urandom,
             int'($urandom_range(0, 2)));
      if (k % 25 == 24) check_mem($sformatf("rnd%0d", k));
    end
    check_mem("final");
    check("re/we overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
